// File: rtl/serial_arith_pkg.sv
// +----------------------------------------------------------------------+
// | serial_arith_pkg: FSM encoding and parameter helpers for serial math |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic bit digit_legal(input int digit);
    return (digit == 1) || (digit == 2) || (digit == 4) || (digit == 8);
  endfunction

  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_addsub_unit_if.sv
// +----------------------------------------------------------------------+
// | serial_addsub_unit_if: operand and result handshake bundle           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface serial_addsub_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_digit_adder.sv
// +----------------------------------------------------------------------+
// | serial_digit_adder: combinational DIGIT-bit adder with carry-in      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_digit_adder
  import serial_arith_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  wire logic [DIGIT-1:0] a,
  input  wire logic [DIGIT-1:0] b,
  input  wire logic             cin,
  output logic      [DIGIT-1:0] s,
  output logic                  cout,
  output logic                  c_top
);

  logic [DIGIT:0] w_total;

  generate
    if (!digit_legal(DIGIT)) begin : g_bad_digit
      $error("serial_digit_adder: DIGIT must be 1, 2, 4 or 8");
    end
  endgenerate

  assign w_total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign s       = w_total[DIGIT-1:0];
  assign cout    = w_total[DIGIT];
  // Recover the carry into the top bit from its sum bit.
  assign c_top   = a[DIGIT-1] ^ b[DIGIT-1] ^ s[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_addsub_unit.sv
// +----------------------------------------------------------------------+
// | serial_addsub_unit: LSB-first digit-serial adder/subtractor          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_addsub_unit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  wire logic           phi,
  input  wire logic           rst_n,
  serial_addsub_unit_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  generate
    if (!digit_legal(DIGIT) || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_addsub_unit: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [DIGIT-1:0]       w_dsum;
  logic                   w_dcout, w_dctop;
  logic [WIDTH+DIGIT-1:0] w_ext;

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (w_dsum),
    .cout  (w_dcout),
    .c_top (w_dctop)
  );

  // New digit enters at the top; after N digits the LSB has reached bit 0.
  assign w_ext = {w_dsum, sum_q};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.op_a;
          b_d        = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d    = bus.sub;
          cnt_d      = '0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = w_ext[WIDTH+DIGIT-1:DIGIT];
        carry_d = w_dcout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          c_out_d     = w_dcout;
          ovf_d       = w_dcout ^ w_dctop;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_unit.sv
// +----------------------------------------------------------------------+
// | tb_serial_addsub_unit: DIGIT=1/4/8 units against an arithmetic model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_addsub_unit;

  localparam int LAT [3] = '{32, 8, 4};
  localparam int DIG [3] = '{1, 4, 8};

  logic        phi = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 phi = ~phi;

  serial_addsub_unit_if #(.WIDTH(32)) if_d1 ();
  serial_addsub_unit_if #(.WIDTH(32)) if_d4 ();
  serial_addsub_unit_if #(.WIDTH(32)) if_d8 ();

  assign if_d1.in_valid = in_valid;  assign if_d1.op_a = op_a;  assign if_d1.op_b = op_b;
  assign if_d1.sub = sub;            assign if_d1.out_ready = out_ready;
  assign if_d4.in_valid = in_valid;  assign if_d4.op_a = op_a;  assign if_d4.op_b = op_b;
  assign if_d4.sub = sub;            assign if_d4.out_ready = out_ready;
  assign if_d8.in_valid = in_valid;  assign if_d8.op_a = op_a;  assign if_d8.op_b = op_b;
  assign if_d8.sub = sub;            assign if_d8.out_ready = out_ready;

  serial_addsub_unit #(.WIDTH(32), .DIGIT(1)) u_d1 (.phi(phi), .rst_n(rst_n), .bus(if_d1));
  serial_addsub_unit #(.WIDTH(32), .DIGIT(4)) u_d4 (.phi(phi), .rst_n(rst_n), .bus(if_d4));
  serial_addsub_unit #(.WIDTH(32), .DIGIT(8)) u_d8 (.phi(phi), .rst_n(rst_n), .bus(if_d8));

  logic        rdy [3];
  logic        vld [3];
  logic        co  [3];
  logic        ov  [3];
  logic [31:0] sm  [3];

  assign rdy[0] = if_d1.in_ready; assign vld[0] = if_d1.out_valid; assign sm[0] = if_d1.sum;
  assign co[0]  = if_d1.c_out;    assign ov[0]  = if_d1.ovf;
  assign rdy[1] = if_d4.in_ready; assign vld[1] = if_d4.out_valid; assign sm[1] = if_d4.sum;
  assign co[1]  = if_d4.c_out;    assign ov[1]  = if_d4.ovf;
  assign rdy[2] = if_d8.in_ready; assign vld[2] = if_d8.out_valid; assign sm[2] = if_d8.sum;
  assign co[2]  = if_d8.c_out;    assign ov[2]  = if_d8.ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract, overflow from signed range.
  function automatic void golden(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] r, output logic c, output logic v);
    longint sa, sb, res;
    logic [32:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r   = a - b;
      c   = (a >= b);
      res = sa - sb;
    end else begin
      t   = {1'b0, a} + {1'b0, b};
      r   = t[31:0];
      c   = t[32];
      res = sa + sb;
    end
    v = (res > 64'sd2147483647) || (res < -64'sd2147483648);
  endfunction

  // Model state per unit: busy flag, edges remaining until result, expected result.
  bit          m_busy [3];
  int          m_left [3];
  logic [31:0] m_sum  [3];
  logic        m_c    [3];
  logic        m_v    [3];

  always @(negedge phi) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_busy[d] = 1'b0;
        m_left[d] = 0;
      end else begin
        check($sformatf("d%0d_in_ready", DIG[d]), rdy[d], !m_busy[d]);
        check($sformatf("d%0d_out_valid", DIG[d]), vld[d], m_busy[d] && m_left[d] == 0);
        if (m_busy[d] && m_left[d] == 0) begin
          check($sformatf("d%0d_sum", DIG[d]), sm[d], m_sum[d]);
          check($sformatf("d%0d_c_out", DIG[d]), co[d], m_c[d]);
          check($sformatf("d%0d_ovf", DIG[d]), ov[d], m_v[d]);
        end
        if (!m_busy[d]) begin
          if (in_valid) begin
            m_busy[d] = 1'b1;
            m_left[d] = LAT[d];
            golden(op_a, op_b, sub, m_sum[d], m_c[d], m_v[d]);
          end
        end else if (m_left[d] > 0) begin
          m_left[d] = m_left[d] - 1;
        end else if (out_ready) begin
          m_busy[d] = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input bit rnd_ready);
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 500) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge phi);
      #1;
      n++;
    end
    check("wait_idle_timeout", 64'(n >= 500), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
    wait_idle(1'b0);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub = s;
    @(posedge phi);
    #1;
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!vld[0] && lat < 200) begin
      @(posedge phi);
      #1;
      lat++;
    end
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] er, input logic ec, input logic ev);
    logic [31:0] r;
    logic c, v;
    int lat;
    golden(a, b, s, r, c, v);
    check("model_pin", {r, c, v}, {er, ec, ev});
    run_op(a, b, s, lat);
    check("d1_latency", lat, 32);
    check("d1_direct_sum", sm[0], er);
    check("d1_direct_c_out", co[0], ec);
    check("d1_direct_ovf", ov[0], ev);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge phi);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("reset_in_ready", rdy[d], 1'b1);
      check("reset_out_valid", vld[d], 1'b0);
      check("reset_sum", sm[d], 32'h0);
      check("reset_c_out", co[d], 1'b0);
      check("reset_ovf", ov[d], 1'b0);
    end
    #2 rst_n = 1'b1;

    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      wait_idle(1'b1);
      in_valid = 1'b1;
      op_a = pick();
      op_b = pick();
      sub = 1'($urandom_range(0, 1));
      @(posedge phi);
      #1;
      in_valid = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
    end
    out_ready = 1'b1;

    // Backpressure: result held while in_valid is asserted with other operands.
    wait_idle(1'b0);
    out_ready = 1'b0;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    in_valid = 1'b1;
    op_a = 32'h0000_0005;
    op_b = 32'h0000_0003;
    sub = 1'b1;
    repeat (10) begin
      @(posedge phi);
      #1;
      check("bp_sum_held", sm[0], 32'h2345_6789);
      check("bp_out_valid", vld[0], 1'b1);
      check("bp_in_ready", rdy[0], 1'b0);
    end
    out_ready = 1'b1;
    @(posedge phi);
    #1;
    check("bp_release_idle", rdy[0], 1'b1);
    check("bp_release_valid", vld[0], 1'b0);
    @(posedge phi);
    #1;
    check("bp_next_accept", rdy[0], 1'b0);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of RUN.
    wait_idle(1'b0);
    in_valid = 1'b1;
    op_a = 32'hAAAA_AAAA;
    op_b = 32'h5555_5555;
    sub = 1'b0;
    @(posedge phi);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge phi);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("mid_reset_in_ready", rdy[d], 1'b1);
      check("mid_reset_out_valid", vld[d], 1'b0);
      check("mid_reset_sum", sm[d], 32'h0);
      check("mid_reset_c_out", co[d], 1'b0);
      check("mid_reset_ovf", ov[d], 1'b0);
    end
    @(posedge phi);
    #3 rst_n = 1'b1;
    check("post_reset_in_ready", rdy[0], 1'b1);
    directed(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

    wait_idle(1'b0);
    repeat (2) @(posedge phi);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
